ifetch_ctrl: RTL and testbench
==============================

// Module: ifetch_ctrl
// PURPOSE
//   Fetch sequencer and PC driver for the multi-cycle core. Takes the current pc from
//   the PC register block and fetches the instruction word over a req/ack
//   instruction-memory port. It holds the word for the datapath, then drives
//   pc_op/imm_J/imm_I back into the PC block for exactly one cycle per retired instruction.
//   pc_op is PC_OP_HALT at all other times, so the PC register only moves on retire.
// PARAMETERS
//   TIMEOUT    16  max cycles in FETCH without imem_ack before fetch_err (>=2)
//   CNT_W      32  width of retired-instruction counter
// PORTS
//   clk          in   1            rising-edge clock
//   rst          in   1            async, active-high reset
//   pc           in   32           current PC from PC register block
//   imem_req     out  1            fetch request, held until ack
//   imem_addr    out  32           fetch address (= pc while imem_req)
//   imem_ack     in   1            word valid this cycle; may be same cycle as req rise
//   imem_rdata   in   32           instruction word, sampled only when imem_req & imem_ack
//   instr        out  32           latched instruction to decoder/datapath
//   instr_valid  out  1            high throughout EXEC
//   exec_done    in   1            datapath finished instr; sampled only in EXEC
//   cmp_eq       in   1            rs==rt from datapath; sampled with exec_done
//   pc_op        out  `PC_OP_LEN   PC opcode, encodings from shared const header
//   imm_J        out  26           instr[25:0]
//   imm_I        out  16           instr[15:0]
//   halted       out  1            core stopped (HALT instr or fetch error)
//   fetch_err    out  1            sticky; imem timeout
//   retired_cnt  out  CNT_W        count of ADVANCE cycles, wraps to 0
// BEHAVIOUR
//   Reset: state=FETCH, instr=0, branch_taken=0, timer=0, retired_cnt=0, halted=0,
//     fetch_err=0, pc_op=PC_OP_HALT, imem_req=1 on the first cycle after reset release.
//   FSM (registered state; outputs decoded from state and registers):
//   - FETCH: imem_req=1, imem_addr=pc, timer++ each cycle.
//     On imem_ack: instr<=imem_rdata, timer<=0, go EXEC.
//     If timer reaches TIMEOUT-1 with no ack: fetch_err<=1, go HALTED. Ack on that same
//     cycle wins and the fetch completes normally.
//   - EXEC: instr_valid=1.
//     If instr[31:26]==6'b111111 (HALT): go HALTED next cycle, exec_done ignored.
//     Else on exec_done: register branch_taken, go ADVANCE.
//       opcode 000100 (BEQ): branch_taken = cmp_eq.
//       opcode 000101 (BNE): branch_taken = !cmp_eq.
//       all others: branch_taken = 0.
//   - ADVANCE: exactly 1 cycle, then FETCH; retired_cnt++ (wraps).
//     pc_op = PC_OP_IMM_JMP if opcode 000010/000011 (J/JAL).
//     pc_op = PC_OP_OFFSET_JMP if branch_taken.
//     pc_op = PC_OP_NEXT_STEP otherwise.
//     The PC block updates at the end of this cycle; FETCH then uses the new pc.
//   - HALTED: halted=1, pc_op=PC_OP_HALT, imem_req=0. Only rst exits this state.
//   pc_op=PC_OP_HALT in FETCH, EXEC and HALTED.
//   imm_J/imm_I come from the instr register and stay stable from EXEC through ADVANCE.
//   imem_req=0 outside FETCH. imem_ack outside FETCH is ignored. exec_done outside
//   EXEC is ignored.
//   Throughput: min 3 cycles/instr (ack same cycle as request, exec_done on first
//   EXEC cycle).
//   Reset mid-operation (any state): all registers return to reset values immediately
//   (async); an in-flight fetch is abandoned and memory must tolerate req dropping.
// TESTING
//   1. pc=0x0, rdata=0x20010005 (ADDI), ack at once, exec_done 1st EXEC cycle ->
//      pc_op=NEXT_STEP in cycle 3 only, retired_cnt=1.
//   2. rdata=0x08000040 (J) -> imm_J=0x0000040, pc_op=IMM_JMP for 1 cycle; next
//      imem_addr equals the pc fed back.
//   3. BEQ 0x1000FFFF with cmp_eq=1 -> OFFSET_JMP, imm_I=0xFFFF; cmp_eq=0 -> NEXT_STEP;
//      BNE is the inverse.
//   4. imem_ack never asserted, TIMEOUT=16 -> fetch_err=1 and halted=1 after 16 FETCH
//      cycles; pc_op stays HALT.
//   5. rdata=0xFC000000 (HALT) -> halted next cycle, exec_done ignored, no further
//      imem_req, retired_cnt unchanged.
//   6. rst pulse during EXEC and again during FETCH -> all outputs return to reset
//      values at once; next fetch uses pc=`PC_INIT.

Source files
------------

// File: rtl/ifetch_ctrl_if.sv
// Instruction-memory request/acknowledge port between the fetch sequencer and
// the instruction memory. The fetch sequencer is the master and the memory is
// the slave.

`ifndef PC_OP_LEN
`define PC_OP_LEN        2
`define PC_OP_NEXT_STEP  2'd0
`define PC_OP_IMM_JMP    2'd1
`define PC_OP_OFFSET_JMP 2'd2
`define PC_OP_HALT       2'd3
`endif

`ifndef PC_INIT
`define PC_INIT 32'h0000_0000
`endif

interface ifetch_ctrl_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer and PC driver for the multi-cycle core.
// Each instruction moves through FETCH -> EXEC -> ADVANCE. In FETCH the word
// at pc is requested from instruction memory. In EXEC the word is held for the
// datapath. In ADVANCE the PC block gets a single-cycle opcode that moves it.
// pc_op is HALT in every other cycle, so the PC register only moves when an
// instruction retires. A HALT instruction or a fetch timeout parks the
// sequencer in HALTED until reset.

`ifndef PC_OP_LEN
`define PC_OP_LEN        2
`define PC_OP_NEXT_STEP  2'd0
`define PC_OP_IMM_JMP    2'd1
`define PC_OP_OFFSET_JMP 2'd2
`define PC_OP_HALT       2'd3
`endif

`ifndef PC_INIT
`define PC_INIT 32'h0000_0000
`endif

module ifetch_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           pc,
  ifetch_ctrl_if.master         imem,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  input  logic                  exec_done,
  input  logic                  cmp_eq,
  output logic [`PC_OP_LEN-1:0] pc_op,
  output logic [25:0]           imm_J,
  output logic [15:0]           imm_I,
  output logic                  halted,
  output logic                  fetch_err,
  output logic [CNT_W-1:0]      retired_cnt
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_ADVANCE,
    S_HALTED
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic            fetch_req;
  logic [5:0]      opcode;
  logic            branch_taken;
  logic [`PC_OP_LEN-1:0] advance_op;

  assign opcode    = instr[31:26];
  assign imm_J     = instr[25:0];
  assign imm_I     = instr[15:0];
  assign imem.req  = fetch_req;
  assign imem.addr = fetch_req ? pc : 32'h0;

  // Branch decision and the PC opcode that the upcoming ADVANCE cycle will present.
  always_comb begin
    branch_taken = 1'b0;
    advance_op   = `PC_OP_NEXT_STEP;
    case (opcode)
      OP_BEQ:  branch_taken = cmp_eq;
      OP_BNE:  branch_taken = !cmp_eq;
      default: branch_taken = 1'b0;
    endcase
    if (opcode == OP_J || opcode == OP_JAL) begin
      advance_op = `PC_OP_IMM_JMP;
    end else if (branch_taken) begin
      advance_op = `PC_OP_OFFSET_JMP;
    end
  end

  // Sequencer state, fetch timer, instruction latch, retire counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_FETCH;
      timer       <= '0;
      instr       <= 32'h0;
      fetch_req   <= 1'b1;
      instr_valid <= 1'b0;
      pc_op       <= `PC_OP_HALT;
      halted      <= 1'b0;
      fetch_err   <= 1'b0;
      retired_cnt <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem.ack) begin
            instr       <= imem.rdata;
            timer       <= '0;
            fetch_req   <= 1'b0;
            instr_valid <= 1'b1;
            state       <= S_EXEC;
          end else if (timer == TIMER_LAST) begin
            fetch_err <= 1'b1;
            halted    <= 1'b1;
            fetch_req <= 1'b0;
            state     <= S_HALTED;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_EXEC: begin
          if (opcode == OP_HALT) begin
            instr_valid <= 1'b0;
            halted      <= 1'b1;
            state       <= S_HALTED;
          end else if (exec_done) begin
            instr_valid <= 1'b0;
            pc_op       <= advance_op;
            state       <= S_ADVANCE;
          end
        end
        S_ADVANCE: begin
          pc_op       <= `PC_OP_HALT;
          fetch_req   <= 1'b1;
          retired_cnt <= retired_cnt + CNT_W'(1);
          state       <= S_FETCH;
        end
        S_HALTED: begin
          halted    <= 1'b1;
          fetch_req <= 1'b0;
          pc_op     <= `PC_OP_HALT;
        end
        default: begin
          state <= S_HALTED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl. It uses a behavioural model of the
// fetch/execute/retire sequence, directed corner cases, and randomized
// instruction streams with random memory and datapath latencies.

`ifndef PC_OP_LEN
`define PC_OP_LEN        2
`define PC_OP_NEXT_STEP  2'd0
`define PC_OP_IMM_JMP    2'd1
`define PC_OP_OFFSET_JMP 2'd2
`define PC_OP_HALT       2'd3
`endif

`ifndef PC_INIT
`define PC_INIT 32'h0000_0000
`endif

module tb_ifetch_ctrl;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 32;

  logic                  clk;
  logic                  rst;
  logic [31:0]           pc;
  logic [31:0]           instr;
  logic                  instr_valid;
  logic                  exec_done;
  logic                  cmp_eq;
  logic [`PC_OP_LEN-1:0] pc_op;
  logic [25:0]           imm_J;
  logic [15:0]           imm_I;
  logic                  halted;
  logic                  fetch_err;
  logic [CNT_W-1:0]      retired_cnt;

  ifetch_ctrl_if imem ();

  ifetch_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .imem        (imem),
    .instr       (instr),
    .instr_valid (instr_valid),
    .exec_done   (exec_done),
    .cmp_eq      (cmp_eq),
    .pc_op       (pc_op),
    .imm_J       (imm_J),
    .imm_I       (imm_I),
    .halted      (halted),
    .fetch_err   (fetch_err),
    .retired_cnt (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // PC opcode that a retiring instruction must produce.
  function automatic logic [`PC_OP_LEN-1:0] model_pc_op(input logic [31:0] w, input logic c);
    case (w[31:26])
      6'h02, 6'h03: return `PC_OP_IMM_JMP;
      6'h04:        return c ? `PC_OP_OFFSET_JMP : `PC_OP_NEXT_STEP;
      6'h05:        return c ? `PC_OP_NEXT_STEP : `PC_OP_OFFSET_JMP;
      default:      return `PC_OP_NEXT_STEP;
    endcase
  endfunction

  // Environment stand-in for the PC register block.
  function automatic logic [31:0] model_next_pc(input logic [31:0] cur, input logic [31:0] w,
                                                input logic [`PC_OP_LEN-1:0] op);
    case (op)
      `PC_OP_IMM_JMP:    return {cur[31:28], w[25:0], 2'b00};
      `PC_OP_OFFSET_JMP: return cur + 32'd4 + {{14{w[15]}}, w[15:0], 2'b00};
      `PC_OP_NEXT_STEP:  return cur + 32'd4;
      default:           return cur;
    endcase
  endfunction

  task automatic check_reset_values(input string tag);
    check_output({tag, "_instr"}, instr, 32'h0);
    check_bit({tag, "_valid"}, instr_valid, 1'b0);
    check_output({tag, "_pc_op"}, 32'(pc_op), 32'(`PC_OP_HALT));
    check_bit({tag, "_req"}, imem.req, 1'b1);
    check_bit({tag, "_halted"}, halted, 1'b0);
    check_bit({tag, "_ferr"}, fetch_err, 1'b0);
    check_output({tag, "_cnt"}, retired_cnt, 32'h0);
  endtask

  // FETCH phase: ack_delay cycles without ack, then ack carrying word.
  task automatic fetch_phase(input logic [31:0] word, input int ack_delay);
    for (int i = 0; i < ack_delay; i++) begin
      imem.ack   = 1'b0;
      imem.rdata = $urandom;
      exec_done  = 1'($urandom);
      #1;
      check_bit("fetch_req", imem.req, 1'b1);
      check_output("fetch_addr", imem.addr, pc);
      check_output("fetch_pc_op", 32'(pc_op), 32'(`PC_OP_HALT));
      check_bit("fetch_halted", halted, 1'b0);
      tick();
    end
    imem.ack   = 1'b1;
    imem.rdata = word;
    exec_done  = 1'($urandom);
    #1;
    check_bit("ack_req", imem.req, 1'b1);
    check_output("ack_addr", imem.addr, pc);
    tick();
    imem.ack = 1'b0;
  endtask

  // EXEC and ADVANCE phases for a non-HALT instruction.
  task automatic exec_phase(input logic [31:0] word, input logic c, input int done_delay);
    logic [`PC_OP_LEN-1:0] exp_op;
    exp_op = model_pc_op(word, c);
    for (int i = 0; i < done_delay; i++) begin
      exec_done  = 1'b0;
      imem.ack   = 1'($urandom);
      imem.rdata = $urandom;
      cmp_eq     = 1'($urandom);
      #1;
      check_bit("exec_valid", instr_valid, 1'b1);
      check_output("exec_instr", instr, word);
      check_output("exec_pc_op", 32'(pc_op), 32'(`PC_OP_HALT));
      check_bit("exec_req", imem.req, 1'b0);
      tick();
    end
    exec_done = 1'b1;
    cmp_eq    = c;
    imem.ack  = 1'b0;
    #1;
    check_bit("done_valid", instr_valid, 1'b1);
    check_output("done_instr", instr, word);
    tick();
    exec_done = 1'b0;
    cmp_eq    = ~c;
    check_output("adv_pc_op", 32'(pc_op), 32'(exp_op));
    check_output("adv_imm_J", {6'b0, imm_J}, {6'b0, word[25:0]});
    check_output("adv_imm_I", {16'b0, imm_I}, {16'b0, word[15:0]});
    check_bit("adv_valid", instr_valid, 1'b0);
    check_bit("adv_req", imem.req, 1'b0);
    pc = model_next_pc(pc, word, exp_op);
    exp_cnt++;
    tick();
    check_output("post_pc_op", 32'(pc_op), 32'(`PC_OP_HALT));
    check_bit("post_req", imem.req, 1'b1);
    check_output("post_addr", imem.addr, pc);
    check_output("post_cnt", retired_cnt, 32'(exp_cnt));
  endtask

  task automatic apply_stimulus(input logic [31:0] word, input logic c,
                                input int ack_delay, input int done_delay);
    fetch_phase(word, ack_delay);
    exec_phase(word, c, done_delay);
  endtask

  // Asynchronous reset pulse placed mid-cycle, released on the falling edge.
  task automatic pulse_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    pc      = `PC_INIT;
    exp_cnt = 0;
    #1;
    check_reset_values(tag);
    check_output({tag, "_addr"}, imem.addr, `PC_INIT);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [5:0] ops [8];
  logic [31:0] w;

  initial begin
    ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2b};
    rst        = 1'b1;
    pc         = `PC_INIT;
    exec_done  = 1'b0;
    cmp_eq     = 1'b0;
    imem.ack   = 1'b0;
    imem.rdata = 32'h0;
    #2;
    check_reset_values("reset0");
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed instruction cases");
    apply_stimulus(32'h20010005, 1'b0, 0, 0);
    apply_stimulus(32'h08000040, 1'b0, 0, 0);
    apply_stimulus(32'h1000FFFF, 1'b1, 0, 0);
    apply_stimulus(32'h1000FFFF, 1'b0, 1, 2);
    apply_stimulus(32'h1400FFFF, 1'b1, 2, 1);
    apply_stimulus(32'h1400FFFF, 1'b0, 0, 0);
    apply_stimulus(32'h0C000010, 1'b0, 3, 0);
    apply_stimulus(32'h20010005, 1'b0, TIMEOUT - 1, 0);

    $display("[TB] randomized instruction stream");
    for (int i = 0; i < 24; i++) begin
      w = {ops[$urandom_range(0, 7)], 26'($urandom)};
      apply_stimulus(w, 1'($urandom), $urandom_range(0, TIMEOUT - 1), $urandom_range(0, 3));
    end

    $display("[TB] reset during EXEC");
    fetch_phase(32'h20010005, 0);
    pulse_reset("rst_exec");

    $display("[TB] reset during FETCH then fetch timeout");
    apply_stimulus(32'h1000FFFF, 1'b1, 0, 0);
    imem.ack = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    pulse_reset("rst_fetch");
    for (int i = 0; i < TIMEOUT; i++) begin
      imem.ack = 1'b0;
      check_bit("to_halted", halted, 1'b0);
      check_bit("to_req", imem.req, 1'b1);
      check_bit("to_ferr", fetch_err, 1'b0);
      tick();
    end
    check_bit("to_halted_end", halted, 1'b1);
    check_bit("to_ferr_end", fetch_err, 1'b1);
    check_bit("to_req_end", imem.req, 1'b0);
    check_output("to_pc_op", 32'(pc_op), 32'(`PC_OP_HALT));
    for (int i = 0; i < 4; i++) begin
      imem.ack   = 1'b1;
      imem.rdata = $urandom;
      tick();
      check_bit("to_stay_halted", halted, 1'b1);
      check_bit("to_stay_req", imem.req, 1'b0);
      check_output("to_stay_pc_op", 32'(pc_op), 32'(`PC_OP_HALT));
    end
    imem.ack = 1'b0;

    $display("[TB] HALT instruction");
    pulse_reset("rst_halt");
    apply_stimulus(32'h20010005, 1'b0, 1, 0);
    fetch_phase(32'hFC000000, 0);
    exec_done = 1'b1;
    #1;
    check_bit("halt_exec_valid", instr_valid, 1'b1);
    check_bit("halt_exec_halted", halted, 1'b0);
    tick();
    check_bit("halt_halted", halted, 1'b1);
    check_bit("halt_ferr", fetch_err, 1'b0);
    check_bit("halt_valid", instr_valid, 1'b0);
    check_output("halt_cnt", retired_cnt, 32'(exp_cnt));
    for (int i = 0; i < 4; i++) begin
      imem.ack  = 1'($urandom);
      exec_done = 1'($urandom);
      tick();
      check_bit("halt_stay_req", imem.req, 1'b0);
      check_output("halt_stay_pc_op", 32'(pc_op), 32'(`PC_OP_HALT));
      check_output("halt_stay_cnt", retired_cnt, 32'(exp_cnt));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
